crc_engine_mc: RTL and testbench
================================

# crc_engine_mc

Multi-channel, parametrised CRC engine that succeeds the single-channel CRC block. It provides NUM_CH independent channels on the same simple register bus (addr / data_wr / rw / sel / data_rd). Each channel has programmable 16- or 32-bit width, polynomial, seed, input/output bit transposition and final XOR. Data writes of 1, 2 or 4 bytes are absorbed into a per-channel buffer and folded into the CRC at one byte per clock, so the result is sequential rather than combinational.

## Interface

- NUM_CH, default 2: number of independent channels, 1..16.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  register address. addr[7:4] selects the channel, addr[3:2] selects the register, other bits are ignored.
- data_wr  input  32  write data.
- rw  input  1  0 = read, 1 = write.
- sel  input  1  device selected; a transfer occurs on each edge where sel=1.
- data_rd  output  32  registered read data.
- busy  output  NUM_CH  per-channel engine busy, mirrors STATUS.BUSY.

## Operation

Per-channel register map, by addr[3:2]:
- 0 DATA:
  - Write with CTRL.WAS=1 loads the seed.
  - Write with WAS=0 queues bytes for the engine.
  - Read returns the post-processed CRC.
- 1 GPOLY: polynomial. Reset value 0x04C11DB7. In 16-bit mode only bits [15:0] are used.
- 2 CTRL: reset value 0x0000_0301.
  - [0] TCRC: 1 = 32-bit, 0 = 16-bit.
  - [1] WAS.
  - [2] FXOR.
  - [3] TOTR: bit-reverse on read.
  - [4] TOT: bit-reverse each input byte.
  - [9:8] WSIZE: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
  - All other bits read 0.
- 3 STATUS:
  - [0] BUSY, read-only.
  - [1] OVF, sticky, write-1-to-clear.

Addressing rules:
- A channel index ≥ NUM_CH reads 0 and ignores writes.
- Let W = 32 if TCRC=1, else 16. CRC state reset value is 0xFFFF_FFFF.

Data write (WAS=0, channel idle):
- Captures the low 8·n bits of data_wr, where n is the WSIZE byte count.
- Bytes are processed most-significant first. Example: 0x31323334 with n=4 feeds 0x31, 0x32, 0x33, 0x34.
- Per byte b: if TOT=1, reverse the bits of b. Then crc ^= b << (W-8). Then repeat 8 times: crc = msb ? (crc<<1) ^ poly : crc<<1, masked to W bits.

Seed write (WAS=1):
- Loads crc <= data_wr masked to W bits, in one cycle.
- The write is dropped if the channel is busy.

Writes while busy:
- Any write to DATA, GPOLY or CTRL of a busy channel is dropped and sets OVF.
- STATUS writes are always accepted.

DATA read value:
- Take crc[W-1:0].
- If TOTR=1, bit-reverse it over W bits.
- If FXOR=1, XOR it with all-ones over W bits.
- Zero-extend to 32 bits.
- A read during BUSY returns the intermediate state.

Per-channel FSM:
- IDLE --DATA write, WAS=0, idle--> RUN, with counter = n.
- RUN: fold one byte per cycle and decrement the counter. counter = 1 → IDLE.

Other rules:
- Channels are fully independent. Simultaneous activity on different channels does not interact.
- Changing TCRC does not alter the stored crc bits; the width mask applies from the next operation.

## Timing

- Reset:
  - crc = 0xFFFF_FFFF, GPOLY = 0x04C11DB7, CTRL = 0x301, STATUS = 0.
  - data_rd = 0, busy = 0. All FSMs go to IDLE.
  - A reset during RUN aborts the operation, and queued bytes are discarded.
- Read latency is 1 cycle:
  - sel=1, rw=0 at edge k → data_rd is valid after edge k.
  - data_rd holds its value until the next read.
- Write effect is visible on edge k+1.
- An n-byte DATA write at edge k:
  - busy=1 after edge k.
  - Bytes are folded on edges k+1 … k+n.
  - busy=0 after edge k+n.
  - A read at edge k+n+1 returns the final value.
- A second DATA write at edge k+n is rejected (channel still busy). A write at edge k+n+1 is accepted.
- A read and a fold on the same edge: the read returns the pre-edge crc.

## Test plan

- **CRC-32/MPEG-2.** Setup: ch0 reset defaults. Stimulus: DATA 0x31323334 (WSIZE=3), 0x35363738, then WSIZE=0 and 0x39, waiting for !busy[0] between writes. Response: DATA read = 0x0376E6E7; busy high exactly 4, 4 and 1 cycles.
- **CRC-32 (reflected).** Setup: CTRL = TCRC|TOT|TOTR|FXOR, WSIZE=0. Stimulus: seed write 0xFFFFFFFF (with WAS), then 9 single-byte writes "123456789". Response: read = 0xCBF43926.
- **16-bit mode.** Setup: ch1 with GPOLY=0x1021, TCRC=0, seed 0xFFFF. Stimulus: "123456789" as bytes. Response: read = 0x000029B1. ch0 state is unchanged.
- **Overflow.** Stimulus: a 4-byte DATA write, then another on the next edge. Response: second write dropped, STATUS = 0x3. Once idle, the result equals the single-word CRC. Writing STATUS=0x2 then reads 0x0.
- **Reset mid-RUN.** Stimulus: assert rst two cycles into a 4-byte fold. Response: busy = 0, and DATA, GPOLY, CTRL, STATUS read 0xFFFFFFFF, 0x04C11DB7, 0x301, 0.
- **Out-of-range channel.** Setup: NUM_CH=2. Stimulus: write, then read, at addr[7:4]=5. Response: data_rd = 0 and no channel state changes.

Source files
------------

// File: rtl/crc_engine_mc.sv
// Multi-channel CRC engine: NUM_CH independent 16/32-bit CRC channels behind one register bus.
// Latency: register read data 1 cycle after the read edge; data writes fold 1 byte per clock (n cycles busy).
// Backpressure: none on the bus; writes to DATA/GPOLY/CTRL of a busy channel are dropped and flag OVF.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   addr[7:4]/[3:2]   channel / register select (other bits ignored)
//   data_wr, rw, sel  write data, 1 = write / 0 = read, transfer strobe
//   data_rd           registered read data, held until the next read
//   busy[NUM_CH]      per-channel engine busy (STATUS.BUSY)
module crc_engine_mc #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_wr,
    input  logic              rw,
    input  logic              sel,
    output logic [31:0]       data_rd,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [31:0] CRC_RST   = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY_RST  = 32'h04C1_1DB7;
    localparam logic [31:0] CTRL_RST  = 32'h0000_0301;
    localparam logic [31:0] CTRL_MASK = 32'h0000_031F;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

    // One byte folded MSB-first into the CRC, width selected by wide (1 = 32 bit).
    function automatic logic [31:0] fold_byte(input logic [31:0] crc, input logic [7:0] b,
                                              input logic [31:0] poly, input logic wide,
                                              input logic tot);
        logic [31:0] c;
        logic [31:0] mask;
        logic [7:0]  bb;
        logic        msb;
        mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        bb   = tot ? rev8(b) : b;
        c    = wide ? (crc ^ {bb, 24'h0}) : (crc ^ {16'h0, bb, 8'h0});
        for (int k = 0; k < 8; k++) begin
            msb = wide ? c[31] : c[15];
            c   = ({c[30:0], 1'b0} ^ (msb ? poly : 32'h0)) & mask;
        end
        return c;
    endfunction

    // Read-side post-processing: mask, optional reverse over W bits, optional final XOR.
    function automatic logic [31:0] post_crc(input logic [31:0] crc, input logic [31:0] ctrl);
        logic [31:0] v;
        logic [31:0] r;
        logic [31:0] mask;
        mask = ctrl[0] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        v    = crc & mask;
        r    = '0;
        if (ctrl[3]) begin
            if (ctrl[0]) begin
                for (int k = 0; k < 32; k++) r[k] = v[31-k];
            end else begin
                for (int k = 0; k < 16; k++) r[k] = v[15-k];
            end
            v = r;
        end
        if (ctrl[2]) v = v ^ mask;
        return v;
    endfunction

    logic [3:0]  ch_idx;
    logic [1:0]  reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic        unused_addr;
    logic [31:0] rd_vals [NUM_CH];

    assign ch_idx      = addr[7:4];
    assign reg_idx     = addr[3:2];
    assign wr_en       = sel & rw;
    assign rd_en       = sel & ~rw;
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t      state_q, state_d;
        logic [31:0] crc_q, crc_d;
        logic [31:0] poly_q, poly_d;
        logic [31:0] ctrl_q, ctrl_d;
        logic        ovf_q, ovf_d;
        logic [2:0]  cnt_q, cnt_d;
        logic [31:0] buf_q, buf_d;   // pending bytes, next byte in [31:24]
        logic        hit;
        logic        run;
        logic [31:0] wmask;
        logic [2:0]  nbytes;
        logic [31:0] buf_load;
        logic [31:0] rd_val;

        assign hit   = wr_en && (ch_idx == 4'(i));
        assign run   = (state_q == S_RUN);
        assign wmask = ctrl_q[0] ? 32'hFFFF_FFFF : 32'h0000_FFFF;

        always_comb begin
            nbytes   = 3'd4;
            buf_load = data_wr;
            case (ctrl_q[9:8])
                2'd0: begin
                    nbytes   = 3'd1;
                    buf_load = {data_wr[7:0], 24'h0};
                end
                2'd1: begin
                    nbytes   = 3'd2;
                    buf_load = {data_wr[15:0], 16'h0};
                end
                default: begin
                    nbytes   = 3'd4;
                    buf_load = data_wr;
                end
            endcase
        end

        always_comb begin
            state_d = state_q;
            crc_d   = crc_q;
            poly_d  = poly_q;
            ctrl_d  = ctrl_q;
            ovf_d   = ovf_q;
            cnt_d   = cnt_q;
            buf_d   = buf_q;

            if (run) begin
                crc_d = fold_byte(crc_q, buf_q[31:24], poly_q, ctrl_q[0], ctrl_q[4]);
                buf_d = {buf_q[23:0], 8'h0};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_IDLE;
            end

            if (hit) begin
                case (reg_idx)
                    2'd0: begin
                        if (run) begin
                            ovf_d = 1'b1;
                        end else if (ctrl_q[1]) begin
                            crc_d = data_wr & wmask;
                        end else begin
                            buf_d   = buf_load;
                            cnt_d   = nbytes;
                            state_d = S_RUN;
                        end
                    end
                    2'd1: begin
                        if (run) ovf_d = 1'b1;
                        else     poly_d = data_wr;
                    end
                    2'd2: begin
                        if (run) ovf_d = 1'b1;
                        else     ctrl_d = data_wr & CTRL_MASK;
                    end
                    default: begin
                        if (data_wr[1]) ovf_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= S_IDLE;
                crc_q   <= CRC_RST;
                poly_q  <= POLY_RST;
                ctrl_q  <= CTRL_RST;
                ovf_q   <= 1'b0;
                cnt_q   <= 3'd0;
                buf_q   <= 32'h0;
            end else begin
                state_q <= state_d;
                crc_q   <= crc_d;
                poly_q  <= poly_d;
                ctrl_q  <= ctrl_d;
                ovf_q   <= ovf_d;
                cnt_q   <= cnt_d;
                buf_q   <= buf_d;
            end
        end

        always_comb begin
            rd_val = 32'h0;
            case (reg_idx)
                2'd0:    rd_val = post_crc(crc_q, ctrl_q);
                2'd1:    rd_val = poly_q;
                2'd2:    rd_val = ctrl_q;
                default: rd_val = {30'h0, ovf_q, run};
            endcase
        end

        assign rd_vals[i] = rd_val;
        assign busy[i]    = run;
    end

    logic [31:0] data_rd_q, data_rd_d;

    always_comb begin
        data_rd_d = data_rd_q;
        if (rd_en) begin
            data_rd_d = 32'h0;   // out-of-range channels read zero
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 4'(c)) data_rd_d = rd_vals[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) data_rd_q <= 32'h0;
        else     data_rd_q <= data_rd_d;
    end

    assign data_rd = data_rd_q;

endmodule

// File: tb/tb_crc_engine_mc.sv
module tb_crc_engine_mc;
    localparam int NUM_CH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       addr;
    logic [31:0]       data_wr;
    logic              rw;
    logic              sel;
    logic [31:0]       data_rd;
    logic [NUM_CH-1:0] busy;

    crc_engine_mc #(.NUM_CH(NUM_CH)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_wr (data_wr),
        .rw      (rw),
        .sel     (sel),
        .data_rd (data_rd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_crc  [NUM_CH];
    logic [31:0] m_poly [NUM_CH];
    logic [31:0] m_ctrl [NUM_CH];
    logic        m_ovf  [NUM_CH];
    int          m_bend [NUM_CH];   // last edge at which the channel is still busy before the edge

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_crc[c]  = 32'hFFFF_FFFF;
            m_poly[c] = 32'h04C1_1DB7;
            m_ctrl[c] = 32'h0000_0301;
            m_ovf[c]  = 1'b0;
            m_bend[c] = -1;
        end
    endtask

    // Bit-serial CRC: one message bit at a time through the LFSR feedback.
    function automatic logic [31:0] m_feed(input logic [31:0] crc, input logic [7:0] b,
                                           input logic [31:0] poly, input logic [31:0] ctrl);
        int          w;
        logic [31:0] mask;
        logic        in_bit;
        logic        fb;
        w    = ctrl[0] ? 32 : 16;
        mask = ctrl[0] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        for (int i = 7; i >= 0; i--) begin
            in_bit = ctrl[4] ? b[7-i] : b[i];
            fb     = crc[w-1] ^ in_bit;
            crc    = crc << 1;
            if (fb) crc = crc ^ poly;
            crc = crc & mask;
        end
        return crc;
    endfunction

    function automatic logic [31:0] m_post(input int ch);
        int          w;
        logic [31:0] mask;
        logic [31:0] v;
        logic [31:0] r;
        w    = m_ctrl[ch][0] ? 32 : 16;
        mask = m_ctrl[ch][0] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        v    = m_crc[ch] & mask;
        if (m_ctrl[ch][3]) begin
            r = 32'h0;
            for (int i = 0; i < w; i++) r[i] = v[w-1-i];
            v = r;
        end
        if (m_ctrl[ch][2]) v = v ^ mask;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input int ch, input int rg, input int e);
        if (ch >= NUM_CH) return 32'h0;
        case (rg)
            0:       return m_post(ch);
            1:       return m_poly[ch];
            2:       return m_ctrl[ch];
            default: return {30'h0, m_ovf[ch], (e <= m_bend[ch])};
        endcase
    endfunction

    task automatic m_write(input int ch, input int rg, input logic [31:0] d, input int e);
        int n;
        if (ch >= NUM_CH) return;
        if (rg == 3) begin
            if (d[1]) m_ovf[ch] = 1'b0;
        end else if (e <= m_bend[ch]) begin
            m_ovf[ch] = 1'b1;
        end else if (rg == 1) begin
            m_poly[ch] = d;
        end else if (rg == 2) begin
            m_ctrl[ch] = d & 32'h0000_031F;
        end else if (m_ctrl[ch][1]) begin
            m_crc[ch] = d & (m_ctrl[ch][0] ? 32'hFFFF_FFFF : 32'h0000_FFFF);
        end else begin
            n = (m_ctrl[ch][9:8] == 2'd0) ? 1 : (m_ctrl[ch][9:8] == 2'd1) ? 2 : 4;
            for (int j = n - 1; j >= 0; j--)
                m_crc[ch] = m_feed(m_crc[ch], d[8*j +: 8], m_poly[ch], m_ctrl[ch]);
            m_bend[ch] = e + n;
        end
    endtask

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = 32'h0;
        for (int c = 0; c < NUM_CH; c++) v[c] = (edge_cnt + 1 <= m_bend[c]);
        return v;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q  [$];
    string       name_q [$];

    initial begin
        logic rd_seen;
        forever begin
            @(posedge clk);
            rd_seen = sel && !rw && !rst;
            @(negedge clk);
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected read: got 0x%08h expected no read", data_rd);
                end else begin
                    check(name_q.pop_front(), data_rd, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- bus tasks (called at a falling edge) ----------------
    function automatic logic [31:0] mk_addr(input int ch, input int rg);
        logic [31:0] a;
        a      = $urandom;
        a[7:4] = ch[3:0];
        a[3:2] = rg[1:0];
        return a;
    endfunction

    task automatic bus_wr(input int ch, input int rg, input logic [31:0] d);
        addr    = mk_addr(ch, rg);
        data_wr = d;
        rw      = 1'b1;
        sel     = 1'b1;
        m_write(ch, rg, d, edge_cnt + 1);
        @(negedge clk);
        sel = 1'b0;
        rw  = 1'b0;
    endtask

    task automatic bus_rd_x(input int ch, input int rg, input string nm, input logic [31:0] expv);
        addr    = mk_addr(ch, rg);
        data_wr = $urandom;
        rw      = 1'b0;
        sel     = 1'b1;
        exp_q.push_back(expv);
        name_q.push_back(nm);
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic bus_rd(input int ch, input int rg, input string nm);
        bus_rd_x(ch, rg, nm, m_read(ch, rg, edge_cnt + 1));
    endtask

    task automatic wait_idle(input int ch);
        if (ch < NUM_CH)
            while (edge_cnt < m_bend[ch]) @(negedge clk);
    endtask

    task automatic busy_len(input int ch, input int n_exp, input string nm);
        int cnt;
        cnt = 0;
        for (int t = 0; t < 32 && busy[ch]; t++) begin
            cnt++;
            @(negedge clk);
        end
        check(nm, 32'(cnt), 32'(n_exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ch, op, rg;
        logic [31:0] d;

        rst = 1'b1; sel = 1'b0; rw = 1'b0; addr = 32'h0; data_wr = 32'h0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset data_rd", data_rd, 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        bus_rd_x(0, 0, "reset DATA", 32'hFFFF_FFFF);
        bus_rd_x(0, 1, "reset GPOLY", 32'h04C1_1DB7);
        bus_rd_x(0, 2, "reset CTRL", 32'h0000_0301);
        bus_rd_x(0, 3, "reset STATUS", 32'h0);

        // CRC-32/MPEG-2 with 4,4,1 byte writes
        bus_wr(0, 0, 32'h3132_3334); busy_len(0, 4, "busy len 4a");
        bus_wr(0, 0, 32'h3536_3738); busy_len(0, 4, "busy len 4b");
        bus_wr(0, 2, 32'h0000_0001);
        bus_wr(0, 0, 32'h0000_0039); busy_len(0, 1, "busy len 1");
        bus_rd_x(0, 0, "crc32 mpeg2", 32'h0376_E6E7);

        // Reflected CRC-32
        bus_wr(0, 2, 32'h0000_001F);
        bus_wr(0, 0, 32'hFFFF_FFFF);
        bus_wr(0, 2, 32'h0000_001D);
        for (int i = 0; i < 9; i++) begin
            bus_wr(0, 0, 32'h31 + i);
            wait_idle(0);
        end
        bus_rd_x(0, 0, "crc32 reflected", 32'hCBF4_3926);

        // 16-bit CCITT on channel 1; channel 0 untouched
        bus_wr(1, 1, 32'h0000_1021);
        bus_wr(1, 2, 32'h0000_0002);
        bus_wr(1, 0, 32'h0000_FFFF);
        bus_wr(1, 2, 32'h0000_0000);
        for (int i = 0; i < 9; i++) begin
            bus_wr(1, 0, 32'h31 + i);
            wait_idle(1);
        end
        bus_rd_x(1, 0, "crc16 ccitt", 32'h0000_29B1);
        bus_rd_x(0, 0, "ch0 unchanged", 32'hCBF4_3926);

        // Overflow: second write one edge later is dropped
        bus_wr(0, 2, 32'h0000_0301);
        bus_wr(0, 0, 32'h3132_3334);
        bus_wr(0, 0, 32'hDEAD_BEEF);
        bus_rd_x(0, 3, "ovf status", 32'h0000_0003);
        wait_idle(0);
        bus_rd(0, 0, "ovf result");
        bus_wr(0, 3, 32'h0000_0002);
        bus_rd_x(0, 3, "ovf cleared", 32'h0);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            ch = (($urandom % 8) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, NUM_CH - 1));
            op = $urandom_range(0, 9);
            wait_idle(ch);
            d = $urandom;
            case (op)
                0, 1: bus_wr(ch, 2, d);
                2:    bus_wr(ch, 1, d);
                3, 4, 5, 6: bus_wr(ch, 0, d);
                7:    bus_wr(ch, 3, d);
                8: begin
                    rg = $urandom_range(0, 3);
                    bus_rd(ch, rg, "rand reg");
                end
                default: begin
                    bus_wr(ch, 0, d);
                    rg = $urandom_range(0, 2);
                    bus_wr(ch, rg, $urandom);
                    bus_rd(ch, 3, "rand status");
                end
            endcase
            check("rand busy", 32'(busy), m_busy_vec());
            wait_idle(ch);
            bus_rd(ch, 0, "rand data");
        end

        // Reset two cycles into a 4-byte fold
        for (int c = 0; c < NUM_CH; c++) wait_idle(c);
        bus_wr(0, 2, 32'h0000_0301);
        bus_wr(0, 0, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check("midrun busy", 32'(busy), 32'h0);
        bus_rd_x(0, 0, "midrun DATA", 32'hFFFF_FFFF);
        bus_rd_x(0, 1, "midrun GPOLY", 32'h04C1_1DB7);
        bus_rd_x(0, 2, "midrun CTRL", 32'h0000_0301);
        bus_rd_x(0, 3, "midrun STATUS", 32'h0);

        // Out-of-range channel
        bus_wr(0, 1, 32'h1111_2222);
        bus_wr(5, 1, 32'hAAAA_5555);
        bus_wr(5, 2, 32'h0000_0000);
        bus_wr(5, 0, 32'h3132_3334);
        check("oor busy", 32'(busy), 32'h0);
        bus_rd_x(5, 0, "oor read", 32'h0);
        bus_rd(0, 1, "oor ch0 poly");
        bus_rd(1, 2, "oor ch1 ctrl");
        bus_rd(1, 0, "oor ch1 data");

        repeat (3) @(negedge clk);
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
